// File: rtl/seg_display_mux.sv
// Multi-digit seven-segment driver: sequential shift-add-3 binary-to-BCD conversion
// feeding a time-multiplexed scanner with saturation, leading-zero blanking and service blink.
module seg_display_mux #(
  parameter int DIGITS       = 2,
  parameter int VAL_W        = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              service_i,
  input  logic              lz_blank_i,
  input  logic              load_i,
  input  logic [VAL_W-1:0]  value_i,
  output logic              busy_o,
  output logic              ovf_o,
  output logic [7:0]        seg_o,
  output logic [DIGITS-1:0] dig_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + VAL_W;
  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [BCD_W-1:0] NINES   = {DIGITS{4'h9}};

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t             r_state;
  logic [SR_W-1:0]    r_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sticky;
  logic               r_busy;
  logic               r_ovf;
  logic [BCD_W-1:0]   r_bcd;

  logic [SR_W-1:0]    w_adj;
  logic [SR_W-1:0]    w_shift;
  logic               w_sticky;

  // NOTE: always_comb uses blocking '=' so later statements see earlier updates; always_ff uses '<='.
  always_comb begin
    w_adj = r_sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_adj[VAL_W + 4*i +: 4] >= 4'd5)
        w_adj[VAL_W + 4*i +: 4] = w_adj[VAL_W + 4*i +: 4] + 4'd3;
    end
  end

  assign w_shift  = {w_adj[SR_W-2:0], 1'b0};
  assign w_sticky = r_sticky | w_adj[SR_W-1];

  // NOTE: reset is synchronous, so it is tested inside the clocked block only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_sr     <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
      r_busy   <= 1'b0;
      r_ovf    <= 1'b0;
      r_bcd    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_i) begin
            r_sr     <= {{BCD_W{1'b0}}, value_i};
            r_cnt    <= CNT_W'(VAL_W);
            r_sticky <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_CONV;
          end
        end
        S_CONV: begin
          r_sr     <= w_shift;
          r_sticky <= w_sticky;
          r_cnt    <= r_cnt - 1'b1;
          // Last shift: commit the freshly shifted nibbles, saturated if anything fell off the top.
          if (r_cnt == CNT_W'(1)) begin
            r_bcd   <= w_sticky ? NINES : w_shift[SR_W-1 -: BCD_W];
            r_ovf   <= w_sticky;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o = r_busy;
  assign ovf_o  = r_ovf;

  logic [PRE_W-1:0]  r_pre;
  logic [IDX_W-1:0]  r_idx;
  logic [FRM_W-1:0]  r_frm;
  logic              r_blink;
  logic [7:0]        r_seg;
  logic [DIGITS-1:0] r_dig;

  logic [PRE_W-1:0]  w_pre_next;
  logic [IDX_W-1:0]  w_idx_next;
  logic [FRM_W-1:0]  w_frm_next;
  logic              w_blink_next;

  always_comb begin
    w_pre_next   = r_pre + 1'b1;
    w_idx_next   = r_idx;
    w_frm_next   = r_frm;
    w_blink_next = r_blink;
    if (r_pre == PRE_MAX) begin
      w_pre_next = '0;
      w_idx_next = (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      if (r_idx == IDX_MAX) begin
        if (r_frm == FRM_MAX) begin
          w_frm_next   = '0;
          w_blink_next = ~r_blink;
        end else begin
          w_frm_next = r_frm + 1'b1;
        end
      end
    end
  end

  function automatic logic [7:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 8'hFC;
      4'd1:    decode = 8'h60;
      4'd2:    decode = 8'hDA;
      4'd3:    decode = 8'hF2;
      4'd4:    decode = 8'h66;
      4'd5:    decode = 8'hB6;
      4'd6:    decode = 8'hBE;
      4'd7:    decode = 8'hE0;
      4'd8:    decode = 8'hFE;
      4'd9:    decode = 8'hF6;
      default: decode = 8'h00;
    endcase
  endfunction

  logic [DIGITS-1:0] w_lz;
  logic              w_zero_acc;
  logic [3:0]        w_digit;
  logic              w_blank_sel;
  logic [7:0]        w_seg;

  // w_lz[k] is set when digit k and every more significant digit are zero.
  always_comb begin
    w_lz       = '0;
    w_zero_acc = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_zero_acc = w_zero_acc & (r_bcd[4*k +: 4] == 4'd0);
      w_lz[k]    = w_zero_acc;
    end
  end

  always_comb begin
    w_digit     = r_bcd[3:0];
    w_blank_sel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_idx_next == IDX_W'(k)) begin
        w_digit     = r_bcd[4*k +: 4];
        w_blank_sel = w_lz[k];
      end
    end
    if (!service_i)
      w_seg = w_blink_next ? 8'h02 : 8'h00;
    else if (lz_blank_i && w_blank_sel)
      w_seg = 8'h00;
    else
      w_seg = decode(w_digit);
  end

  // Pattern is recomputed every clock so input and commit changes show on the next edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pre   <= '0;
      r_idx   <= '0;
      r_frm   <= '0;
      r_blink <= 1'b1;
      r_seg   <= 8'h00;
      r_dig   <= DIGITS'(1);
    end else begin
      r_pre   <= w_pre_next;
      r_idx   <= w_idx_next;
      r_frm   <= w_frm_next;
      r_blink <= w_blink_next;
      r_seg   <= w_seg;
      r_dig   <= DIGITS'(1) << w_idx_next;
    end
  end

  assign seg_o = r_seg;
  assign dig_o = r_dig;

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboard bench for seg_display_mux: commits are checked against queued expectations,
// the scanned display against a small digit/blanking model.
module tb_seg_display_mux;

  localparam int DIGITS       = 2;
  localparam int VAL_W        = 8;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             service_i = 1'b1;
  logic             lz_blank_i = 1'b0;
  logic             load_i = 1'b0;
  logic [VAL_W-1:0] value_i = '0;
  logic             busy_o;
  logic             ovf_o;
  logic [7:0]       seg_o;
  logic [DIGITS-1:0] dig_o;

  seg_display_mux #(
    .DIGITS(DIGITS), .VAL_W(VAL_W), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .service_i(service_i), .lz_blank_i(lz_blank_i),
    .load_i(load_i), .value_i(value_i), .busy_o(busy_o), .ovf_o(ovf_o),
    .seg_o(seg_o), .dig_o(dig_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [3:0] m_tens = 4'd0;
  logic [3:0] m_ones = 4'd0;

  function automatic logic [7:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 8'hFC; 4'd1: dec = 8'h60; 4'd2: dec = 8'hDA; 4'd3: dec = 8'hF2;
      4'd4: dec = 8'h66; 4'd5: dec = 8'hB6; 4'd6: dec = 8'hBE; 4'd7: dec = 8'hE0;
      4'd8: dec = 8'hFE; 4'd9: dec = 8'hF6; default: dec = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int k);
    if (k == 0) return dec(m_ones);
    if (lz_blank_i && m_tens == 4'd0) return 8'h00;
    return dec(m_tens);
  endfunction

  task automatic run_load(input int v, input int pulse_at);
    exp_t e;
    int busy_n;
    logic [VAL_W-1:0] vv;
    vv     = VAL_W'(v);
    e.ovf  = (v > 99);
    e.tens = e.ovf ? 4'd9 : 4'(v / 10);
    e.ones = e.ovf ? 4'd9 : 4'(v % 10);
    sb.push_back(e);
    @(negedge clk_i);
    load_i = 1'b1; value_i = vv;
    @(negedge clk_i);
    load_i = 1'b0;
    busy_n = 0;
    for (int c = 0; c < 20 && busy_o === 1'b1; c++) begin
      busy_n++;
      if (busy_n == pulse_at) begin
        load_i = 1'b1; value_i = 8'd13;
      end else begin
        load_i = 1'b0;
      end
      @(negedge clk_i);
    end
    load_i = 1'b0;
    n_vec++;
    if (busy_n !== 8) begin
      n_err++; $display("FAIL busy_len(%0d): got %0d cycles, want 8", v, busy_n);
    end
    e = sb.pop_front();
    n_vec++;
    if (ovf_o !== e.ovf) begin
      n_err++; $display("FAIL ovf(%0d): got %b, want %b", v, ovf_o, e.ovf);
    end
    m_tens = e.tens;
    m_ones = e.ones;
  endtask

  task automatic check_display(input string tag, input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      n_vec++;
      if (dig_o === 2'b01) k = 0;
      else if (dig_o === 2'b10) k = 1;
      else begin
        n_err++; $display("FAIL %s dig_onehot: got %b, want 01 or 10", tag, dig_o);
        continue;
      end
      if (seg_o !== exp_seg(k)) begin
        n_err++; $display("FAIL %s seg digit%0d: got %h, want %h", tag, k, seg_o, exp_seg(k));
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; load_i = 1'b1; value_i = 8'd5;
    repeat (3) @(negedge clk_i);
    n_vec++;
    if (seg_o !== 8'h00 || dig_o !== 2'b01) begin
      n_err++; $display("FAIL reset_outputs: got seg=%h dig=%b, want seg=00 dig=01", seg_o, dig_o);
    end
    n_vec++;
    if (busy_o !== 1'b0 || ovf_o !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: got busy=%b ovf=%b, want 0 0", busy_o, ovf_o);
    end
    rst_i = 1'b0; load_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if (busy_o !== 1'b0) begin
      n_err++; $display("FAIL reset_beats_load: got busy=%b, want 0", busy_o);
    end
    n_vec++;
    if (seg_o !== 8'hFC || dig_o !== 2'b01) begin
      n_err++; $display("FAIL post_reset_display: got seg=%h dig=%b, want FC 01", seg_o, dig_o);
    end
  endtask

  task automatic test_convert_42();
    logic [DIGITS-1:0] prev;
    int run, full;
    logic first;
    run_load(42, 0);
    check_display("d42", 16);
    @(negedge clk_i);
    prev = dig_o; run = 1; first = 1'b1; full = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_i);
      if (dig_o === prev) run++;
      else begin
        if (!first) begin
          n_vec++; full++;
          if (run !== SCAN_DIV) begin
            n_err++; $display("FAIL scan_hold: got %0d clocks, want %0d", run, SCAN_DIV);
          end
        end
        first = 1'b0; prev = dig_o; run = 1;
      end
    end
    n_vec++;
    if (full < 3) begin
      n_err++; $display("FAIL scan_runs: got %0d full runs, want >=3", full);
    end
  endtask

  task automatic test_overflow();
    run_load(123, 0);
    check_display("d123", 8);
    run_load(99, 0);
    check_display("d99", 8);
  endtask

  task automatic test_blanking();
    @(negedge clk_i); lz_blank_i = 1'b1;
    run_load(7, 0);
    check_display("lz7", 8);
    lz_blank_i = 1'b0;
    check_display("nolz7", 8);
    lz_blank_i = 1'b1;
    run_load(0, 0);
    check_display("lz0", 8);
    lz_blank_i = 1'b0;
  endtask

  task automatic test_ignored_load();
    int busy_seen;
    run_load(42, 3);
    check_display("ign42", 8);
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (busy_o !== 1'b0) busy_seen++;
    end
    n_vec++;
    if (busy_seen !== 0) begin
      n_err++; $display("FAIL ignored_load_idle: got %0d busy cycles, want 0", busy_seen);
    end
  endtask

  task automatic test_service();
    logic [7:0] prev;
    int run, full;
    logic first;
    @(negedge clk_i); service_i = 1'b0;
    @(negedge clk_i);
    prev = seg_o; run = 1; first = 1'b1; full = 0;
    n_vec++;
    if (seg_o !== 8'h02 && seg_o !== 8'h00) begin
      n_err++; $display("FAIL service_pattern: got %h, want 02 or 00", seg_o);
    end
    for (int i = 0; i < 72; i++) begin
      @(negedge clk_i);
      if (seg_o !== 8'h02 && seg_o !== 8'h00) begin
        n_vec++; n_err++; $display("FAIL service_pattern: got %h, want 02 or 00", seg_o);
      end
      if (seg_o === prev) run++;
      else begin
        if (!first) begin
          n_vec++; full++;
          if (run !== 16) begin
            n_err++; $display("FAIL blink_phase: got %0d clocks, want 16", run);
          end
        end
        first = 1'b0; prev = seg_o; run = 1;
      end
    end
    n_vec++;
    if (full < 3) begin
      n_err++; $display("FAIL blink_runs: got %0d full phases, want >=3", full);
    end
    service_i = 1'b1;
    check_display("svc_release", 8);
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int busy_n, busy_seen;
    e.tens = 4'd5; e.ones = 4'd5; e.ovf = 1'b0;
    sb.push_back(e);
    @(negedge clk_i); load_i = 1'b1; value_i = 8'd55;
    @(negedge clk_i); load_i = 1'b0;
    busy_n = 0;
    for (int c = 0; c < 20 && busy_o === 1'b1 && busy_n < 4; c++) begin
      busy_n++;
      if (busy_n == 4) rst_i = 1'b1;
      @(negedge clk_i);
    end
    n_vec++;
    if (busy_n !== 4) begin
      n_err++; $display("FAIL abort_reach: got %0d busy cycles, want 4", busy_n);
    end
    rst_i = 1'b1;
    n_vec++;
    if (busy_o !== 1'b0 || ovf_o !== 1'b0 || seg_o !== 8'h00 || dig_o !== 2'b01) begin
      n_err++;
      $display("FAIL abort_reset: got busy=%b ovf=%b seg=%h dig=%b, want 0 0 00 01",
               busy_o, ovf_o, seg_o, dig_o);
    end
    rst_i = 1'b0;
    void'(sb.pop_back());
    m_tens = 4'd0; m_ones = 4'd0;
    @(negedge clk_i);
    n_vec++;
    if (seg_o !== 8'hFC || dig_o !== 2'b01) begin
      n_err++; $display("FAIL abort_display: got seg=%h dig=%b, want FC 01", seg_o, dig_o);
    end
    busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (busy_o !== 1'b0 || ovf_o !== 1'b0) busy_seen++;
    end
    n_vec++;
    if (busy_seen !== 0) begin
      n_err++; $display("FAIL abort_no_commit: got %0d busy/ovf cycles, want 0", busy_seen);
    end
    check_display("abort", 8);
    n_vec++;
    if (sb.size() !== 0) begin
      n_err++; $display("FAIL scoreboard_left: got %0d entries, want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_convert_42();
    test_overflow();
    test_blanking();
    test_ignored_load();
    test_service();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

Parametrised multi-digit seven-segment driver for the intersection's countdown and status displays. It captures a binary value on a load strobe and converts it to BCD with a sequential shift-add-3 engine, one bit per clock. It then drives one shared segment bus with time-multiplexed one-hot digit enables. It adds overflow saturation, leading-zero blanking and a blinking service pattern.

## Interface
- DIGITS, 2, number of decimal digits driven (1..8); digit 0 is least significant.
- VAL_W, 8, width of the binary input value (1..27).
- SCAN_DIV, 1000, clocks each digit stays enabled (>=1).
- BLINK_FRAMES, 50, scan frames per service blink phase (>=1); frame = DIGITS digit periods.

- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- service_i  in  1  service request, active-low (0 = service mode).
- lz_blank_i  in  1  1 = blank leading zeros.
- load_i  in  1  capture strobe for value_i; honoured only when busy_o = 0.
- value_i  in  VAL_W  unsigned binary value to display.
- busy_o  out  1  conversion in progress.
- ovf_o  out  1  last committed value exceeded 10^DIGITS-1.
- seg_o  out  8  segment pattern, active-high; bit7..bit1 = a..g, bit0 = dp.
- dig_o  out  DIGITS  one-hot digit enable, active-high.

## Operation
- Reset values: seg_o = 8'h00, dig_o = 1 (digit 0), busy_o = 0, ovf_o = 0, committed BCD = all zero, prescaler = 0, digit index = 0, frame count = 0, blink phase = on.
- Converter FSM has states IDLE and CONV.
  - IDLE: load_i = 1 latches value_i into the shift register, clears BCD work nibbles and the overflow sticky bit, loads the bit counter with VAL_W, and moves to CONV.
  - CONV, once per cycle: add 3 to every BCD work nibble >= 5, then shift the whole {BCD, binary} register left by 1. A 1 shifted out of the top nibble sets the overflow sticky bit. Decrement the counter.
  - CONV exit: after the VAL_W-th shift, commit to the display registers. Committed digits = all 9s if sticky, else the work nibbles. ovf_o = sticky. Return to IDLE.
- load_i while busy_o = 1 is ignored; there is no queueing.
- Display registers change only on commit. The previous value stays displayed during conversion.
- Scanner:
  - The prescaler counts 0..SCAN_DIV-1. On wrap, the digit index advances (DIGITS-1 wraps to 0).
  - On index wrap, the frame count advances. On frame count reaching BLINK_FRAMES-1 it clears and the blink phase toggles.
- Pattern selection for the selected digit k, in priority order:
  - service_i = 0: 8'h02 (g only) when blink phase on, 8'h00 when off. Conversion continues underneath.
  - lz_blank_i = 1, k != 0, and committed digits k..DIGITS-1 all zero: 8'h00.
  - otherwise the decoded digit: 0 = FC, 1 = 60, 2 = DA, 3 = F2, 4 = 66, 5 = B6, 6 = BE, 7 = E0, 8 = FE, 9 = F6.
  - Digit 0 is never blanked.

## Timing
- Load sampled at edge t:
  - busy_o = 1 from t+1 through t+VAL_W.
  - Commit at edge t+VAL_W. busy_o = 0, new digits and ovf_o visible from t+VAL_W (registered, after that edge).
- A load_i high in the commit cycle is sampled at the edge where busy_o falls. It is ignored because busy_o is still 1 at that edge.
- seg_o and dig_o are registered together. Both update on the edge where the prescaler wraps, so they never disagree.
- Pattern changes from service_i, lz_blank_i or commit appear on the next edge, not at the next digit switch.
- Reset asserted mid-conversion aborts it: nothing is committed and all reset values apply at the next edge.
- Simultaneous rst_i and load_i: reset wins.

## Test plan
Use DIGITS=2, VAL_W=8, SCAN_DIV=4, BLINK_FRAMES=2.
- Load 42, lz_blank_i=0:
  - busy_o high exactly 8 cycles, ovf_o = 0.
  - Display shows seg_o = DA with dig_o = 01 and 66 with dig_o = 10, each held 4 clocks, alternating.
- Load 123: after 8 cycles, ovf_o = 1 and both digits show F6. Then load 99: ovf_o = 0, both digits show F6.
- Load 7 with lz_blank_i=1: digit 1 = 00, digit 0 = E0.
  - Change lz_blank_i to 0: digit 1 = FC.
  - Load 0 with lz_blank_i=1: digit 0 = FC, digit 1 = 00.
- Load 42, then pulse load_i with value 13 on cycle 3 of busy: the pulse is ignored and the display commits 42.
- service_i=0 after 42 is displayed: both digits show 02 for 16 clocks, then 00 for 16 clocks, repeating. Releasing service_i restores DA/66.
- Assert rst_i on cycle 4 of converting 55: outputs take reset values, no commit occurs, and the display shows FC with dig_o = 01 after reset.
